fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Shares the single frame-buffer write port (we / trail_addr / write) between three burst requesters: the screen-clear engine, the blue trail writer and the red trail writer. Clear always wins at a burst boundary; the two trail writers alternate round-robin. Trail traffic is limited by a per-frame word budget that refills on each frame_clk rising edge. The block sits between the trail writers/clear engine and the on-chip frame buffer.

## Interface
- ADDR_W, 20, frame-buffer word address width
- DATA_W, 16, frame-buffer word width
- BUDGET, 4096, max trail words that may *start* bursts per frame
- MAX_BURST, 64, watchdog: a burst ends after this many accepted words
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  frame tick (~60 Hz, synchronous to Clk, ≥2 cycles high)
- Game_State  in  3  game state; 3'b010 = playing
- clr_req, b_req, r_req  in  1 each  requester has a valid word
- clr_addr, b_addr, r_addr  in  ADDR_W each  word address
- clr_data, b_data, r_data  in  DATA_W each  word data
- clr_last, b_last, r_last  in  1 each  current word ends the burst
- clr_ack, b_ack, r_ack  out  1 each  word accepted this cycle (combinational)
- we  out  1  frame-buffer write enable (registered)
- trail_addr  out  ADDR_W  frame-buffer address (registered)
- write  out  DATA_W  frame-buffer data (registered)
- owner  out  2  0 none, 1 clear, 2 blue, 3 red (registered state)
- budget_exhausted  out  1  trail word count ≥ BUDGET

## Operation
- States: IDLE, G_CLR, G_B, G_R. owner mirrors the state.
- IDLE: if clr_req → G_CLR. Else if Game_State==3'b010 and !budget_exhausted: the requester pointed to by rr_ptr if its req is high, else the other if its req is high → G_B/G_R. Else stay.
- Grant state: ack = owner's req. When ack is high, the word is accepted and burst_cnt increments.
- Burst end: accepted word with last=1, or burst_cnt reaching MAX_BURST → IDLE. Leaving G_B sets rr_ptr=red; leaving G_R sets rr_ptr=blue.
- Stall: owner drops req mid-burst → stay in the grant state with ack=0 and we=0 the next cycle. There is no timeout.
- Abort: in G_B/G_R, if Game_State≠3'b010 → IDLE immediately. ack=0 that cycle, so no word is accepted. G_CLR ignores Game_State and budget.
- Budget counter (width ≥ clog2(BUDGET+MAX_BURST)+1, saturating):
  - counts accepted trail words only.
  - frame_clk rising edge is detected against a registered copy of frame_clk.
  - on that edge the counter loads 1 if a trail word is accepted that cycle, else 0.
  - a burst in progress may overrun BUDGET; only new trail grants are blocked.
- Clear requests pre-empt only at burst boundaries, never mid-burst.

## Timing
- Reset values: state IDLE, owner 0, we 0, trail_addr 0, write 0, rr_ptr blue, burst_cnt 0, budget count 0, frame_clk register 0. All acks are 0 while in IDLE.
- Grant latency: req seen in IDLE at cycle t → grant state at t+1 → first ack at t+1.
- Write latency: a word acked at cycle t appears on we/trail_addr/write at t+1. we is 0 in every other cycle.
- An N-word burst with req held high takes 1 grant cycle + N ack cycles. There is 1 mandatory IDLE cycle between consecutive bursts.
- Reset mid-burst: state IDLE and we=0 from the next edge. The partial burst is dropped; requesters must re-request.
- Simultaneous clr_req and trail reqs in IDLE: clear wins. rr_ptr is unchanged.
- Simultaneous b_req and r_req: rr_ptr decides.

## Test plan
- Reset, then b_req with a 3-word burst (addr 100..102, data A,B,C, last on the 3rd) → b_ack high for 3 cycles. we high for 3 cycles one cycle later with addr 100,101,102. owner=2 during the burst, then 0.
- b_req and r_req held high continuously with 2-word bursts → grant order blue, red, blue, red. Each burst is separated by one IDLE cycle.
- A blue burst is in progress and clr_req rises → the blue burst completes. clear is granted next even though r_req is pending, then red is granted.
- BUDGET=4 with blue issuing 3-word bursts → the 1st burst is granted and the count reaches 3. The 2nd burst is granted and completes, leaving the count at 6 and budget_exhausted=1. No 3rd grant until the frame_clk rising edge, after which the count is 0 and a grant follows.
- Game_State drops from 3'b010 to 3'b000 mid red burst → same cycle r_ack=0, then owner=0 and no further we. A clear burst still runs in Game_State 3'b000.
- MAX_BURST=4 with blue holding req high and never asserting last → exactly 4 acks, then IDLE. Red is granted next if requesting.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: clear engine beats the two trail writers at
// burst boundaries, trail writers alternate and share a per-frame word budget.
module fb_write_arbiter #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 16,
   parameter int BUDGET    = 4096,
   parameter int MAX_BURST = 64
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_clk,
   input  logic [2:0]        Game_State,
   input  logic              clr_req,
   input  logic              b_req,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] clr_data,
   input  logic [DATA_W-1:0] b_data,
   input  logic [DATA_W-1:0] r_data,
   input  logic              clr_last,
   input  logic              b_last,
   input  logic              r_last,
   output logic              clr_ack,
   output logic              b_ack,
   output logic              r_ack,
   output logic              we,
   output logic [ADDR_W-1:0] trail_addr,
   output logic [DATA_W-1:0] write,
   output logic [1:0]        owner,
   output logic              budget_exhausted
);

   localparam int CNT_W   = $clog2(BUDGET + MAX_BURST) + 1;
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam logic [2:0] PLAYING = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      G_CLR = 2'd1,
      G_B   = 2'd2,
      G_R   = 2'd3
   } state_t;

   state_t              state;
   state_t              next_state;
   logic                rr_red;
   logic [BURST_W-1:0]  burst_cnt;
   logic [CNT_W-1:0]    budget_cnt;
   logic                frame_clk_q;
   logic                playing;
   logic                accept;
   logic                trail_accept;
   logic                burst_done;
   logic                frame_edge;
   logic                cur_last;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_data;

   assign playing          = (Game_State == PLAYING);
   assign budget_exhausted = (budget_cnt >= CNT_W'(BUDGET));
   assign frame_edge       = frame_clk & ~frame_clk_q;
   assign owner            = state;
   assign accept           = clr_ack | b_ack | r_ack;
   assign trail_accept     = b_ack | r_ack;
   assign burst_done       = accept & (cur_last | (burst_cnt == BURST_W'(MAX_BURST - 1)));

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= next_state;
   end

   // A trail owner loses its ack the moment the game leaves the playing state
   always_comb begin
      clr_ack  = 1'b0;
      b_ack    = 1'b0;
      r_ack    = 1'b0;
      cur_addr = clr_addr;
      cur_data = clr_data;
      cur_last = clr_last;
      unique case (state)
         G_CLR: clr_ack = clr_req;
         G_B: begin
            b_ack    = b_req & playing;
            cur_addr = b_addr;
            cur_data = b_data;
            cur_last = b_last;
         end
         G_R: begin
            r_ack    = r_req & playing;
            cur_addr = r_addr;
            cur_data = r_data;
            cur_last = r_last;
         end
         default: ;
      endcase
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (clr_req) begin
               next_state = G_CLR;
            end else if (playing && !budget_exhausted) begin
               if (!rr_red) begin
                  if (b_req)      next_state = G_B;
                  else if (r_req) next_state = G_R;
               end else begin
                  if (r_req)      next_state = G_R;
                  else if (b_req) next_state = G_B;
               end
            end
         end
         G_CLR:   if (burst_done) next_state = IDLE;
         default: if (!playing || burst_done) next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         burst_cnt <= '0;
         rr_red    <= 1'b0;
      end else begin
         if (next_state == IDLE) burst_cnt <= '0;
         else if (accept)        burst_cnt <= burst_cnt + 1'b1;
         if (state == G_B && next_state == IDLE)      rr_red <= 1'b1;
         else if (state == G_R && next_state == IDLE) rr_red <= 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         we         <= 1'b0;
         trail_addr <= '0;
         write      <= '0;
      end else begin
         we <= accept;
         if (accept) begin
            trail_addr <= cur_addr;
            write      <= cur_data;
         end
      end
   end

   // The refill edge still counts a trail word accepted in that same cycle
   always_ff @(posedge Clk) begin
      if (Reset) begin
         budget_cnt  <= '0;
         frame_clk_q <= 1'b0;
      end else begin
         frame_clk_q <= frame_clk;
         if (frame_edge)
            budget_cnt <= CNT_W'(trail_accept);
         else if (trail_accept && budget_cnt != {CNT_W{1'b1}})
            budget_cnt <= budget_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized and directed bench for fb_write_arbiter, checked every cycle
// against a word/burst level reference model.
module tb_fb_write_arbiter;

   localparam int ADDR_W    = 20;
   localparam int DATA_W    = 16;
   localparam int BUDGET_P  = 8;
   localparam int MAX_P     = 4;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              frame_clk;
   logic [2:0]        Game_State;
   logic              clr_req, b_req, r_req;
   logic [ADDR_W-1:0] clr_addr, b_addr, r_addr;
   logic [DATA_W-1:0] clr_data, b_data, r_data;
   logic              clr_last, b_last, r_last;
   logic              clr_ack, b_ack, r_ack;
   logic              we;
   logic [ADDR_W-1:0] trail_addr;
   logic [DATA_W-1:0] write;
   logic [1:0]        owner;
   logic              budget_exhausted;

   fb_write_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUDGET(BUDGET_P), .MAX_BURST(MAX_P)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
      .clr_req(clr_req), .b_req(b_req), .r_req(r_req),
      .clr_addr(clr_addr), .b_addr(b_addr), .r_addr(r_addr),
      .clr_data(clr_data), .b_data(b_data), .r_data(r_data),
      .clr_last(clr_last), .b_last(b_last), .r_last(r_last),
      .clr_ack(clr_ack), .b_ack(b_ack), .r_ack(r_ack),
      .we(we), .trail_addr(trail_addr), .write(write),
      .owner(owner), .budget_exhausted(budget_exhausted)
   );

   always #5 Clk = ~Clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Requester sources: channel 0 clear, 1 blue, 2 red
   int                s_total [3];
   int                s_blen  [3];
   int                s_pos   [3];
   logic [ADDR_W-1:0] s_addr  [3];
   logic [DATA_W-1:0] s_data  [3];
   bit                s_stall [3];

   bit       rand_mode = 0;
   logic     tb_reset  = 1'b1;
   logic     tb_frame  = 1'b0;
   logic [2:0] tb_gs   = 3'b010;
   logic     r_rst     = 1'b0;
   logic [2:0] r_gs    = 3'b010;
   int       frame_cnt = 0;

   logic [ADDR_W-1:0] wr_log[$];
   logic [DATA_W-1:0] wr_dlog[$];
   int                grant_log[$];
   int                prev_owner = 0;
   int                b_ack_cnt  = 0;

   // Reference model state: owner id, words in current burst, next trail in line
   int                m_owner     = 0;
   int                m_words     = 0;
   int                m_next_tr   = 2;
   int                m_budget    = 0;
   logic              m_fprev     = 1'b0;
   logic              m_we        = 1'b0;
   logic [ADDR_W-1:0] m_addr      = '0;
   logic [DATA_W-1:0] m_data      = '0;
   logic              m_acc [3]   = '{1'b0, 1'b0, 1'b0};

   function automatic logic [2:0] exp_acks(input int own, input logic c, input logic b,
                                           input logic r, input logic [2:0] gs);
      logic [2:0] a;
      a    = 3'b000;
      a[0] = (own == 1) && c;
      a[1] = (own == 2) && b && (gs == 3'b010);
      a[2] = (own == 3) && r && (gs == 3'b010);
      return a;
   endfunction

   always @(posedge Clk) begin
      logic [2:0] a;
      logic       playing;
      logic       exh;
      logic       ending;
      playing = (Game_State == 3'b010);
      a       = exp_acks(m_owner, clr_req, b_req, r_req, Game_State);
      if (Reset) begin
         m_owner = 0; m_words = 0; m_next_tr = 2; m_budget = 0; m_fprev = 1'b0;
         m_we = 1'b0; m_addr = '0; m_data = '0;
         for (int i = 0; i < 3; i++) m_acc[i] = 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) m_acc[i] = a[i];
         exh  = (m_budget >= BUDGET_P);
         m_we = (a != 3'b000);
         if (a[0])      begin m_addr = clr_addr; m_data = clr_data; end
         else if (a[1]) begin m_addr = b_addr;   m_data = b_data;   end
         else if (a[2]) begin m_addr = r_addr;   m_data = r_data;   end
         if (frame_clk && !m_fprev) m_budget = (a[1] || a[2]) ? 1 : 0;
         else                       m_budget = m_budget + ((a[1] || a[2]) ? 1 : 0);
         m_fprev = frame_clk;
         ending  = 1'b0;
         case (m_owner)
            0: begin
               if (clr_req) m_owner = 1;
               else if (playing && !exh) begin
                  if (m_next_tr == 2) begin
                     if (b_req) m_owner = 2; else if (r_req) m_owner = 3;
                  end else begin
                     if (r_req) m_owner = 3; else if (b_req) m_owner = 2;
                  end
               end
            end
            1: if (a[0]) begin
               m_words++;
               ending = clr_last || (m_words == MAX_P);
            end
            default: begin
               if (!playing) ending = 1'b1;
               else if (a != 3'b000) begin
                  m_words++;
                  ending = ((m_owner == 2) ? b_last : r_last) || (m_words == MAX_P);
               end
            end
         endcase
         if (ending) begin
            if (m_owner == 2)      m_next_tr = 3;
            else if (m_owner == 3) m_next_tr = 2;
            m_owner = 0;
            m_words = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      logic [2:0] a;
      a = exp_acks(m_owner, clr_req, b_req, r_req, Game_State);
      check("clr_ack", 32'(clr_ack), 32'(a[0]));
      check("b_ack",   32'(b_ack),   32'(a[1]));
      check("r_ack",   32'(r_ack),   32'(a[2]));
      check("owner",   32'(owner),   32'(m_owner));
      check("we",      32'(we),      32'(m_we));
      if (m_we) begin
         check("trail_addr", 32'(trail_addr), 32'(m_addr));
         check("write",      32'(write),      32'(m_data));
      end
      check("budget_exhausted", 32'(budget_exhausted), 32'(m_budget >= BUDGET_P));
      if (we === 1'b1) begin
         wr_log.push_back(trail_addr);
         wr_dlog.push_back(write);
      end
      if (owner != 2'd0 && prev_owner == 0) grant_log.push_back(int'(owner));
      prev_owner = int'(owner);
      if (b_ack === 1'b1) b_ack_cnt++;
   endtask

   task automatic applyStimulus();
      for (int ch = 0; ch < 3; ch++) begin
         if (m_acc[ch]) begin
            s_addr[ch]  = s_addr[ch] + 1'b1;
            s_data[ch]  = s_data[ch] + 1'b1;
            s_total[ch] = s_total[ch] - 1;
            s_pos[ch]   = (s_blen[ch] != 0 && s_pos[ch] + 1 == s_blen[ch]) ? 0 : s_pos[ch] + 1;
         end
      end
      if (rand_mode) begin
         for (int ch = 0; ch < 3; ch++) begin
            s_stall[ch] = ($urandom_range(0, 4) == 0);
            if (s_total[ch] == 0 && $urandom_range(0, (ch == 0) ? 15 : 5) == 0) begin
               s_total[ch] = $urandom_range(1, 9);
               s_blen[ch]  = $urandom_range(0, 5);
               s_pos[ch]   = 0;
               s_addr[ch]  = ADDR_W'($urandom);
               s_data[ch]  = DATA_W'($urandom);
            end
         end
         if ($urandom_range(0, 40) == 0) r_gs = (r_gs == 3'b010) ? 3'($urandom_range(0, 7)) : 3'b010;
         r_rst     = ($urandom_range(0, 400) == 0);
         frame_cnt = frame_cnt + 1;
      end else begin
         for (int ch = 0; ch < 3; ch++) s_stall[ch] = 1'b0;
      end
      Reset      = rand_mode ? r_rst : tb_reset;
      Game_State = rand_mode ? r_gs  : tb_gs;
      frame_clk  = rand_mode ? ((frame_cnt % 23) < 3) : tb_frame;
      clr_req  = (s_total[0] > 0) && !s_stall[0];
      b_req    = (s_total[1] > 0) && !s_stall[1];
      r_req    = (s_total[2] > 0) && !s_stall[2];
      clr_addr = s_addr[0]; b_addr = s_addr[1]; r_addr = s_addr[2];
      clr_data = s_data[0]; b_data = s_data[1]; r_data = s_data[2];
      clr_last = (s_blen[0] != 0) && (s_pos[0] == s_blen[0] - 1);
      b_last   = (s_blen[1] != 0) && (s_pos[1] == s_blen[1] - 1);
      r_last   = (s_blen[2] != 0) && (s_pos[2] == s_blen[2] - 1);
   endtask

   initial begin
      for (int ch = 0; ch < 3; ch++) begin
         s_total[ch] = 0; s_blen[ch] = 0; s_pos[ch] = 0;
         s_addr[ch] = '0; s_data[ch] = '0; s_stall[ch] = 1'b0;
      end
      applyStimulus();
      forever begin
         @(negedge Clk);
         checkOutput();
         applyStimulus();
      end
   end

   task automatic step();
      @(negedge Clk);
      #1;
   endtask

   task automatic start_src(input int ch, input int total, input int blen,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      s_total[ch] = total; s_blen[ch] = blen; s_pos[ch] = 0;
      s_addr[ch]  = addr;  s_data[ch] = data;
   endtask

   task automatic clearLogs();
      wr_log.delete();
      wr_dlog.delete();
      grant_log.delete();
      b_ack_cnt = 0;
   endtask

   task automatic doReset();
      for (int ch = 0; ch < 3; ch++) s_total[ch] = 0;
      tb_gs    = 3'b010;
      tb_frame = 1'b0;
      tb_reset = 1'b1;
      repeat (3) step();
      tb_reset = 1'b0;
      step();
      clearLogs();
   endtask

   task automatic waitOwner(input int val, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (int'(owner) == val) break;
         step();
      end
      check("wait_owner", 32'(owner), 32'(val));
   endtask

   initial begin
      $display("[TB] start");
      step();
      doReset();
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_exhausted", 32'(budget_exhausted), 32'd0);

      // Single 3-word blue burst
      start_src(1, 3, 3, 20'd100, 16'hA);
      repeat (8) step();
      check("t1_words", 32'(wr_log.size()), 32'd3);
      check("t1_addr0", 32'(wr_log[0]), 32'd100);
      check("t1_addr2", 32'(wr_log[2]), 32'd102);
      check("t1_data1", 32'(wr_dlog[1]), 32'hB);
      check("t1_b_acks", 32'(b_ack_cnt), 32'd3);
      check("t1_grants", 32'(grant_log.size()), 32'd1);
      check("t1_owner_end", 32'(owner), 32'd0);

      // Both trail writers busy: strict alternation
      doReset();
      start_src(1, 4, 2, 20'h100, 16'h1000);
      start_src(2, 4, 2, 20'h180, 16'h2000);
      repeat (20) step();
      check("t2_grants", 32'(grant_log.size()), 32'd4);
      check("t2_g0", 32'(grant_log[0]), 32'd2);
      check("t2_g1", 32'(grant_log[1]), 32'd3);
      check("t2_g2", 32'(grant_log[2]), 32'd2);
      check("t2_g3", 32'(grant_log[3]), 32'd3);
      check("t2_words", 32'(wr_log.size()), 32'd8);

      // Clear arriving mid-burst waits, then beats the pending red request
      doReset();
      start_src(1, 3, 3, 20'h200, 16'h3000);
      start_src(2, 2, 2, 20'h280, 16'h4000);
      waitOwner(2, 10);
      step();
      start_src(0, 2, 2, 20'h2C0, 16'h5000);
      repeat (15) step();
      check("t3_g0", 32'(grant_log[0]), 32'd2);
      check("t3_g1", 32'(grant_log[1]), 32'd1);
      check("t3_g2", 32'(grant_log[2]), 32'd3);
      check("t3_words", 32'(wr_log.size()), 32'd7);

      // Budget blocks new trail grants until the frame tick
      doReset();
      start_src(1, 12, 3, 20'h600, 16'h6000);
      repeat (25) step();
      check("t4_grants", 32'(grant_log.size()), 32'd3);
      check("t4_words", 32'(wr_log.size()), 32'd9);
      check("t4_exhausted", 32'(budget_exhausted), 32'd1);
      check("t4_owner_idle", 32'(owner), 32'd0);
      tb_frame = 1'b1;
      repeat (2) step();
      tb_frame = 1'b0;
      repeat (8) step();
      check("t4_regrant", 32'(grant_log.size()), 32'd4);
      check("t4_words2", 32'(wr_log.size()), 32'd12);
      check("t4_refilled", 32'(budget_exhausted), 32'd0);

      // Leaving the playing state aborts a red burst; clear still runs
      doReset();
      start_src(2, 3, 3, 20'h400, 16'h7000);
      waitOwner(3, 10);
      tb_gs = 3'b000;
      repeat (3) step();
      check("t5_owner_abort", 32'(owner), 32'd0);
      check("t5_words", 32'(wr_log.size()), 32'd1);
      start_src(0, 2, 2, 20'h500, 16'h8000);
      repeat (6) step();
      check("t5_clr_words", 32'(wr_log.size()), 32'd3);
      check("t5_clr_addr", 32'(wr_log[1]), 32'h500);
      check("t5_clr_grant", 32'(grant_log[1]), 32'd1);

      // Watchdog ends a blue burst that never flags last
      doReset();
      start_src(1, 6, 0, 20'h200, 16'h9000);
      start_src(2, 2, 2, 20'h300, 16'hA000);
      repeat (16) step();
      check("t6_g0", 32'(grant_log[0]), 32'd2);
      check("t6_g1", 32'(grant_log[1]), 32'd3);
      check("t6_last_blue", 32'(wr_log[3]), 32'h203);
      check("t6_first_red", 32'(wr_log[4]), 32'h300);

      // Reset in the middle of a burst drops it
      doReset();
      start_src(1, 3, 3, 20'h700, 16'hB000);
      waitOwner(2, 10);
      step();
      tb_reset = 1'b1;
      repeat (2) step();
      check("t7_owner", 32'(owner), 32'd0);
      check("t7_we", 32'(we), 32'd0);
      tb_reset = 1'b0;
      step();

      // Randomized traffic against the model
      rand_mode = 1;
      repeat (3000) step();
      rand_mode = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
